// File: rtl/alu_div_pkg.sv
// Shared types and constants for the sequential RV32M divide unit.
package alu_div_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// One restoring radix-2 step: shift in the next dividend bit, trial-subtract the divisor.
module alu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_quo_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_trial;
  logic           w_ge;

  assign w_trial = {i_rem, i_quo_msb};
  assign w_ge    = (w_trial >= {1'b0, i_dvs});
  // Partial remainder stays below the divisor, so a successful difference fits in WIDTH bits.
  assign o_rem   = w_ge ? (w_trial[WIDTH-1:0] - i_dvs) : w_trial[WIDTH-1:0];
  assign o_qbit  = w_ge;

endmodule

// File: rtl/alu_seq_divider.sv
// Iterative DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// Optional macro ALU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish right after accept.
module alu_seq_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       r_state;
  logic             r_is_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_div0;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div0;
  logic             w_ovf;
  logic             w_accept;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_signed = (div_op_e'(op) == DIV) || (div_op_e'(op) == REM);
  assign w_a_neg  = w_signed & dividend[WIDTH-1];
  assign w_b_neg  = w_signed & divisor[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -dividend : dividend;
  assign w_b_mag  = w_b_neg ? -divisor : divisor;
  assign w_div0   = (divisor == '0);
  assign w_ovf    = w_signed && (dividend == MIN_VAL) && (divisor == '1);
  assign w_accept = start && !flush && ((r_state == IDLE) || (r_state == DONE));

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem    (r_rem),
    .i_quo_msb(r_quo[WIDTH-1]),
    .i_dvs    (r_dvs),
    .o_rem    (w_rem_nxt),
    .o_qbit   (w_qbit)
  );

  // Special cases override the iterated values; divide-by-zero quotient skips sign correction.
  assign w_quo_fix = r_div0 ? '1 : (r_ovf ? MIN_VAL : (r_q_neg ? -r_quo : r_quo));
  assign w_rem_fix = r_ovf ? '0 : (r_r_neg ? -r_rem : r_rem);

`ifdef ALU_DIV_EARLY_OUT_EN
  logic [WIDTH-1:0] w_special_res;
  assign w_special_res = w_div0 ? (op[1] ? dividend : '1) : (op[1] ? '0 : MIN_VAL);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_is_rem <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_is_rem <= op[1];
            r_quo    <= w_a_mag;
            r_rem    <= '0;
            r_dvs    <= w_b_mag;
            r_cnt    <= CNT_W'(WIDTH);
            r_q_neg  <= w_a_neg ^ w_b_neg;
            r_r_neg  <= w_a_neg;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            r_busy   <= 1'b1;
            r_state  <= CALC;
`ifdef ALU_DIV_EARLY_OUT_EN
            if (w_div0 || w_ovf) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= DONE;
            end
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= FIX;
          end
        end
        FIX: begin
          r_busy <= 1'b0;
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed and randomized checks of alu_seq_divider against an arithmetic reference.
module tb_alu_seq_divider;

`ifdef ALU_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errs   = 0;

  logic [1:0]  rnd_o;
  logic [31:0] rnd_a;
  logic [31:0] rnd_b;
  int          sel;
  int          edges;
  int          bcnt;
  int          dcnt;
  int          bsy_cnt;

  alu_seq_divider dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .dividend(dividend),
    .divisor (divisor),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after the accept edge (or later, with e0 edges already elapsed).
  task automatic wait_done(input int e0, output int n_edges, output int n_busy);
    n_edges = e0;
    n_busy = 0;
    while (!done && n_edges < 80) begin
      if (busy) n_busy++;
      @(posedge clk);
      #1 n_edges++;
    end
  endtask

  task automatic watch(input int n, output int n_done, output int n_busy);
    n_done = 0;
    n_busy = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
      if (busy) n_busy++;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat_exp;
    int e;
    int bc;
    logic [31:0] exp_res;
    exp_res = ref_model(o, a, b);
    lat_exp = (EARLY && is_special(o, a, b)) ? 1 : 34;
    issue(o, a, b);
    wait_done(1, e, bc);
    check({tag, " result"}, result, exp_res);
    check({tag, " latency"}, e, lat_exp);
    check({tag, " busy_cycles"}, bc, lat_exp - 1);
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " result_hold"}, result, exp_res);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    dividend = '0;
    divisor = '0;

    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_check("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_check("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_check("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    run_check("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_check("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
    run_check("divu_5_0", 2'b01, 32'd5, 32'd0);
    run_check("remu_5_0", 2'b11, 32'd5, 32'd0);
    run_check("div_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0);
    run_check("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0);
    run_check("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("div_min_1", 2'b00, 32'h8000_0000, 32'd1);

    for (int i = 0; i < 24; i++) begin
      rnd_o = 2'($urandom_range(0, 3));
      rnd_a = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rnd_b = 32'd0;
      else if (sel == 1) rnd_b = $urandom_range(1, 15);
      else if (sel == 2) begin
        rnd_a = 32'h8000_0000;
        rnd_b = 32'hFFFF_FFFF;
      end else rnd_b = $urandom;
      run_check($sformatf("rand%0d", i), rnd_o, rnd_a, rnd_b);
    end

    // Back-to-back: second start issued during the done cycle.
    issue(2'b01, 32'd200, 32'd9);
    wait_done(1, edges, bcnt);
    check("b2b first result", result, 32'd22);
    check("b2b first latency", edges, 34);
    issue(2'b11, 32'd200, 32'd9);
    wait_done(1, edges, bcnt);
    check("b2b second result", result, 32'd2);
    check("b2b second latency", edges, 34);
    check("b2b second busy_cycles", bcnt, 33);

    // Start while busy is ignored and not queued.
    watch(3, dcnt, bsy_cnt);
    issue(2'b01, 32'd1000, 32'd10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op = 2'b11;
    dividend = 32'd7;
    divisor = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(6, edges, bcnt);
    check("busy_start result", result, 32'd100);
    check("busy_start latency", edges, 34);
    watch(40, dcnt, bsy_cnt);
    check("busy_start no_extra_done", dcnt, 0);
    check("busy_start no_extra_busy", bsy_cnt, 0);

    // Flush at the tenth CALC edge.
    issue(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush result", result, 32'd100);
    watch(40, dcnt, bsy_cnt);
    check("flush no_done", dcnt, 0);
    check("flush result_hold", result, 32'd100);
    run_check("after_flush_divu_9_3", 2'b01, 32'd9, 32'd3);

    // Flush in IDLE blocks a simultaneous start.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op = 2'b01;
    dividend = 32'd50;
    divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_blocks_start busy", {31'd0, busy}, 32'd0);
    watch(40, dcnt, bsy_cnt);
    check("flush_blocks_start no_done", dcnt, 0);
    check("flush_blocks_start result", result, 32'd3);

    // Asynchronous reset mid-CALC.
    issue(2'b01, 32'd50, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst busy", {31'd0, busy}, 32'd0);
    check("async_rst done", {31'd0, done}, 32'd0);
    check("async_rst result", result, 32'd0);
    #1 rst = 1'b0;
    watch(40, dcnt, bsy_cnt);
    check("async_rst no_done", dcnt, 0);
    check("async_rst no_busy", bsy_cnt, 0);
    check("async_rst result_hold", result, 32'd0);

    run_check("after_rst_div", 2'b00, 32'hFFFF_FF9C, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_divider.md
Name: alu_seq_divider

Overview:
- Iterative RV32M divide unit (DIV, DIVU, REM, REMU) upstream of the ALU result-select mux; its `result` drives one data input of that mux.
- Restoring radix-2 algorithm, one quotient bit per clock; valid/busy/done handshake with the issue stage.
- Result register holds its value until the next accepted operation, so the mux can sample it at any time after `done`.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived, not overridable).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request; accepted only when busy=0.
- op, input, 2, 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept.
- dividend, input, WIDTH, rs1 value; sampled at accept.
- divisor, input, WIDTH, rs2 value; sampled at accept.
- flush, input, 1, synchronous abort of the in-flight operation.
- busy, output, 1, operation in progress; start is ignored while high.
- done, output, 1, one-cycle pulse marking result valid.
- result, output, WIDTH, quotient or remainder per the latched op.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0; counter and operand registers cleared. Reset asserted mid-operation abandons the operation and produces no done.
- FSM states IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at an edge (accept edge): latch op; latch |dividend| and |divisor| (two's-complement magnitude for signed ops, raw values for unsigned); latch quotient-sign and remainder-sign flags; clear partial remainder; counter=WIDTH; go to CALC; busy=1.
- CALC, once per edge:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude on a WIDTH+1-bit datapath. If non-negative, keep the difference and set quo[0]=1; otherwise keep rem and set quo[0]=0.
  - Decrement counter. When counter reaches 1 at this edge, go to FIX.
- FIX, one edge:
  - Apply sign correction. Quotient is negated if dividend sign ≠ divisor sign. Remainder takes the dividend's sign.
  - Select quotient or remainder into result. Go to DONE.
- DONE, one cycle: done=1, busy=0.
  - start=1 here is accepted (back-to-back issue); next state CALC.
  - Otherwise next state IDLE.
- Latency: done is high in the cycle after the (WIDTH+2)th edge counted from the accept edge (34 edges for WIDTH=32).
- Divide by zero (divisor=0):
  - DIV/DIVU return all ones.
  - REM/REMU return dividend unmodified.
  - Forced in FIX; quotient sign correction is bypassed.
- Signed overflow (DIV/REM, dividend=100…0, divisor=all ones):
  - DIV returns 100…0.
  - REM returns 0.
  - Forced in FIX.
- flush=1 in CALC or FIX: next state IDLE, busy=0, no done, result unchanged. flush has priority over start at the same edge. flush in IDLE or DONE has no effect, except that it blocks a start at the same edge.
- start while busy=1 is ignored; no queueing.
- result changes only at the FIX edge; it is stable from done through the next accept.

Optional Feature:
- Macro: ALU_DIV_EARLY_OUT_EN.
- Defined: at the accept edge, divide-by-zero and signed-overflow cases skip CALC and FIX.
  - The special result is written at the accept edge and the next state is DONE.
  - done is high in the cycle immediately after the accept edge.
  - busy stays 0 for these cases.
- Not defined: special cases take full WIDTH+2 latency. Results are identical to the defined case; only timing differs.

Decomposition:
- Package alu_div_pkg holds:
  - div_op_e enum (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11);
  - div_state_e enum (IDLE, CALC, FIX, DONE);
  - localparam DIV_W=32.
- One natural sub-module, alu_div_step: combinational single restoring step. It takes rem, quo MSB and divisor magnitude, and returns the next rem and the quotient bit.

Test Plan:
- DIVU 100/7 and REMU 100/7 → result 14 and 2. done asserted exactly 34 edges after accept; busy high for 33 cycles.
- DIV 0xFFFFFFF9(−7)/2 → 0xFFFFFFFD(−3). REM → 0xFFFFFFFF(−1). REM 7/−2 → 1.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. Check 34-edge latency without the macro and 1-edge latency with ALU_DIV_EARLY_OUT_EN.
- Issue start again during the done cycle → second op accepted with no idle gap. Assert start while busy mid-CALC → ignored, first result unaffected.
- Pulse flush at edge 10 of CALC → busy=0 next cycle, no done, result retains its prior value. A fresh DIVU 9/3 afterwards → 3.
- Assert rst asynchronously mid-CALC → busy, done, result go to 0 immediately without waiting for clk; no done after release.
